// File: rtl/avg_raster_pkg.sv
// Shared types and widths for the AVG line rasterizer.
// The optional clip window is enabled with the AVG_RAST_CLIP_EN macro.
package avg_raster_pkg;

  localparam int DEF_COORD_W = 10;
  localparam int DEF_COLOR_W = 3;
  localparam int ERR_W       = DEF_COORD_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_DRAW  = 2'd2
  } rast_state_t;

  // Bresenham error term needs two extra bits: one for sign, one for dx+dy headroom.
  function automatic int err_width(input int coord_w);
    return coord_w + 2;
  endfunction

endpackage

// File: rtl/avg_line_setup.sv
// Combinational Bresenham setup: deltas, step directions and initial error
// from the latched command endpoints.
module avg_line_setup
  import avg_raster_pkg::*;
#(
  parameter  int COORD_W = DEF_COORD_W,
  localparam int EW      = err_width(COORD_W)
) (
  input  logic [COORD_W-1:0]  i_x0,
  input  logic [COORD_W-1:0]  i_y0,
  input  logic [COORD_W-1:0]  i_x1,
  input  logic [COORD_W-1:0]  i_y1,
  output logic [COORD_W-1:0]  o_dx,
  output logic [COORD_W-1:0]  o_dy,
  output logic                o_sx_neg,
  output logic                o_sy_neg,
  output logic signed [EW-1:0] o_err
);

  always_comb begin
    o_sx_neg = (i_x1 < i_x0);
    o_sy_neg = (i_y1 < i_y0);
    o_dx     = o_sx_neg ? (i_x0 - i_x1) : (i_x1 - i_x0);
    o_dy     = o_sy_neg ? (i_y0 - i_y1) : (i_y1 - i_y0);
    o_err    = $signed({2'b00, o_dx}) - $signed({2'b00, o_dy});
  end

endmodule

// File: rtl/avg_line_rasterizer.sv
// AVG vector-to-pixel rasterizer: IDLE/SETUP/DRAW FSM with a Bresenham stepper.
// Define AVG_RAST_CLIP_EN to suppress writes outside X_MAX/Y_MAX.
module avg_line_rasterizer
  import avg_raster_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int COLOR_W = DEF_COLOR_W,
  parameter int X_MAX   = 1023,
  parameter int Y_MAX   = 1023
) (
  input  logic               clk_sys,
  input  logic               reset_l,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x0,
  input  logic [COORD_W-1:0] cmd_y0,
  input  logic [COORD_W-1:0] cmd_x1,
  input  logic [COORD_W-1:0] cmd_y1,
  input  logic [COLOR_W-1:0] cmd_color,
  output logic [COORD_W-1:0] pixel_x_o,
  output logic [COORD_W-1:0] pixel_y_o,
  output logic [COLOR_W-1:0] pixel_c_o,
  output logic               pixel_write,
  input  logic               pixel_wr_full,
  output logic               busy,
  output logic               line_done
);

  localparam int EW = err_width(COORD_W);
  localparam logic [COORD_W-1:0] L_ONE   = COORD_W'(1);
  localparam logic [COORD_W-1:0] L_X_MAX = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] L_Y_MAX = COORD_W'(Y_MAX);

  rast_state_t          r_state;
  logic [COORD_W-1:0]   r_x0, r_y0, r_x1, r_y1, r_x, r_y, r_dx, r_dy;
  logic [COLOR_W-1:0]   r_color;
  logic                 r_sx_neg, r_sy_neg;
  logic signed [EW-1:0] r_err;
  logic [COORD_W-1:0]   r_px, r_py;
  logic [COLOR_W-1:0]   r_pc;
  logic                 r_pixel_write, r_line_done, r_busy, r_cmd_ready;

  logic [COORD_W-1:0]   w_dx, w_dy, w_x_next, w_y_next;
  logic                 w_sx_neg, w_sy_neg, w_step_x, w_step_y, w_at_end;
  logic                 w_in_window, w_visible;
  logic signed [EW-1:0] w_err_init, w_err_next;
  logic signed [EW:0]   w_e2, w_dx_e, w_dy_e;

  avg_line_setup #(.COORD_W(COORD_W)) u_setup (
    .i_x0     (r_x0),
    .i_y0     (r_y0),
    .i_x1     (r_x1),
    .i_y1     (r_y1),
    .o_dx     (w_dx),
    .o_dy     (w_dy),
    .o_sx_neg (w_sx_neg),
    .o_sy_neg (w_sy_neg),
    .o_err    (w_err_init)
  );

  // Both step decisions use the error value from before this step.
  assign w_e2     = {r_err, 1'b0};
  assign w_dx_e   = $signed({3'b000, r_dx});
  assign w_dy_e   = $signed({3'b000, r_dy});
  assign w_step_x = (w_e2 >= -w_dy_e);
  assign w_step_y = (w_e2 <= w_dx_e);
  assign w_at_end = (r_x == r_x1) && (r_y == r_y1);

  always_comb begin
    w_err_next = r_err;
    if (w_step_x) w_err_next = w_err_next - $signed({2'b00, r_dy});
    if (w_step_y) w_err_next = w_err_next + $signed({2'b00, r_dx});
    w_x_next = r_x;
    if (w_step_x) w_x_next = r_sx_neg ? (r_x - L_ONE) : (r_x + L_ONE);
    w_y_next = r_y;
    if (w_step_y) w_y_next = r_sy_neg ? (r_y - L_ONE) : (r_y + L_ONE);
  end

  assign w_in_window = (r_x <= L_X_MAX) && (r_y <= L_Y_MAX);
`ifdef AVG_RAST_CLIP_EN
  assign w_visible = w_in_window;
`else
  assign w_visible = w_in_window | 1'b1;
`endif

  always_ff @(posedge clk_sys or negedge reset_l) begin
    if (!reset_l) begin
      r_state       <= ST_IDLE;
      r_x0 <= '0; r_y0 <= '0; r_x1 <= '0; r_y1 <= '0;
      r_x  <= '0; r_y  <= '0; r_dx <= '0; r_dy <= '0;
      r_color       <= '0;
      r_sx_neg      <= 1'b0;
      r_sy_neg      <= 1'b0;
      r_err         <= '0;
      r_px          <= '0;
      r_py          <= '0;
      r_pc          <= '0;
      r_pixel_write <= 1'b0;
      r_line_done   <= 1'b0;
      r_busy        <= 1'b0;
      r_cmd_ready   <= 1'b1;
    end else begin
      r_pixel_write <= 1'b0;
      r_line_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_busy <= cmd_valid;
          if (cmd_valid) begin
            r_x0        <= cmd_x0;
            r_y0        <= cmd_y0;
            r_x1        <= cmd_x1;
            r_y1        <= cmd_y1;
            r_color     <= cmd_color;
            r_cmd_ready <= 1'b0;
            r_state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_dx     <= w_dx;
          r_dy     <= w_dy;
          r_sx_neg <= w_sx_neg;
          r_sy_neg <= w_sy_neg;
          r_err    <= w_err_init;
          r_x      <= r_x0;
          r_y      <= r_y0;
          r_busy   <= 1'b1;
          r_state  <= ST_DRAW;
        end
        ST_DRAW: begin
          r_busy <= 1'b1;
          // A stall sampled here suppresses this slot; stepper holds its point.
          if (!pixel_wr_full) begin
            r_pixel_write <= w_visible;
            r_px          <= r_x;
            r_py          <= r_y;
            r_pc          <= r_color;
            if (w_at_end) begin
              r_line_done <= 1'b1;
              r_cmd_ready <= 1'b1;
              r_state     <= ST_IDLE;
            end else begin
              r_x   <= w_x_next;
              r_y   <= w_y_next;
              r_err <= w_err_next;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign pixel_x_o   = r_px;
  assign pixel_y_o   = r_py;
  assign pixel_c_o   = r_pc;
  assign pixel_write = r_pixel_write;
  assign busy        = r_busy;
  assign line_done   = r_line_done;

endmodule

// File: tb/tb_avg_line_rasterizer.sv
// Scoreboard bench for avg_line_rasterizer: directed lines with hand-computed pixels.
// Build with AVG_RAST_CLIP_EN defined to add the clip-window case.
module tb_avg_line_rasterizer;

  logic       clk_sys = 1'b0;
  logic       reset_l = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [9:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
  logic [2:0] cmd_color = '0;
  logic [9:0] pixel_x_o, pixel_y_o;
  logic [2:0] pixel_c_o;
  logic       pixel_write;
  logic       pixel_wr_full = 1'b0;
  logic       busy;
  logic       line_done;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] c;
    bit         vis;
    bit         last;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_wr   = 0;

  always #5 clk_sys = ~clk_sys;

  avg_line_rasterizer #(
    .COORD_W (10),
    .COLOR_W (3),
`ifdef AVG_RAST_CLIP_EN
    .X_MAX   (2),
`else
    .X_MAX   (1023),
`endif
    .Y_MAX   (1023)
  ) dut (
    .clk_sys       (clk_sys),
    .reset_l       (reset_l),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_x0        (cmd_x0),
    .cmd_y0        (cmd_y0),
    .cmd_x1        (cmd_x1),
    .cmd_y1        (cmd_y1),
    .cmd_color     (cmd_color),
    .pixel_x_o     (pixel_x_o),
    .pixel_y_o     (pixel_y_o),
    .pixel_c_o     (pixel_c_o),
    .pixel_write   (pixel_write),
    .pixel_wr_full (pixel_wr_full),
    .busy          (busy),
    .line_done     (line_done)
  );

  // Monitor: every write or line_done pops one expected entry.
  always @(negedge clk_sys) begin
    if (reset_l && (pixel_write || line_done)) begin
      exp_t e;
      n_cmp++;
      if (pixel_write) n_wr++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pixel: got (%0d,%0d) c=%0d wr=%0b done=%0b, required none",
                 pixel_x_o, pixel_y_o, pixel_c_o, pixel_write, line_done);
      end else begin
        e = q.pop_front();
        if (pixel_write !== e.vis || line_done !== e.last ||
            (e.vis && (pixel_x_o !== e.x || pixel_y_o !== e.y || pixel_c_o !== e.c))) begin
          n_fail++;
          $display("FAIL pixel: got (%0d,%0d) c=%0d wr=%0b done=%0b, required (%0d,%0d) c=%0d wr=%0b done=%0b",
                   pixel_x_o, pixel_y_o, pixel_c_o, pixel_write, line_done,
                   e.x, e.y, e.c, e.vis, e.last);
        end else begin
          $display("pixel (%0d,%0d) c=%0d done=%0b ok", pixel_x_o, pixel_y_o, pixel_c_o, line_done);
        end
      end
    end
  end

  task automatic push_px(input int x, input int y, input int c, input bit vis, input bit last);
    exp_t e;
    e.x = 10'(x); e.y = 10'(y); e.c = 3'(c); e.vis = vis; e.last = last;
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic got, input logic req);
    n_cmp++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0b, required %0b", name, got, req);
    end else begin
      $display("check %s = %0b ok", name, got);
    end
  endtask

  task automatic check_int(input string name, input int got, input int req);
    n_cmp++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end else begin
      $display("check %s = %0d ok", name, got);
    end
  endtask

  // Holds cmd_valid until accepted; returns #1 after the accepting edge.
  task automatic issue(input int x0, input int y0, input int x1, input int y1, input int c);
    int n;
    cmd_x0 = 10'(x0); cmd_y0 = 10'(y0); cmd_x1 = 10'(x1); cmd_y1 = 10'(y1);
    cmd_color = 3'(c);
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    if (!cmd_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: got cmd_ready=0, required 1");
    end
    @(posedge clk_sys);
    #1 cmd_valid = 1'b0;
    $display("cmd (%0d,%0d)->(%0d,%0d) c=%0d accepted", x0, y0, x1, y1, c);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk_sys);
      if (!busy && !pixel_write && q.size() == 0) done = 1;
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL idle_timeout: got busy=%0b pending=%0d, required idle", busy, q.size());
    end
  endtask

  initial begin
    int seen;
    int wr0;
    bit got_done;

    repeat (3) @(negedge clk_sys);
    reset_l = 1'b1;
    @(negedge clk_sys);
    check("reset_cmd_ready", cmd_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_pixel_write", pixel_write, 1'b0);
    check("reset_line_done", line_done, 1'b0);

    // Horizontal line with first-write latency check.
    for (int i = 0; i < 4; i++) push_px(i, 0, 5, 1, i == 3);
    issue(0, 0, 3, 0, 5);
    @(negedge clk_sys);
    check("lat_busy_after_accept", busy, 1'b1);
    check("lat_slot1_write", pixel_write, 1'b0);
    @(negedge clk_sys);
    check("lat_slot2_write", pixel_write, 1'b0);
    @(negedge clk_sys);
    check("lat_slot3_write", pixel_write, 1'b1);
    wait_idle();

    // Diagonal toward the origin.
    for (int i = 0; i < 4; i++) push_px(5 - i, 5 - i, 2, 1, i == 3);
    issue(5, 5, 2, 2, 2);
    wait_idle();

    // Steep line.
    push_px(0, 0, 7, 1, 0);
    push_px(0, 1, 7, 1, 0);
    push_px(1, 2, 7, 1, 0);
    push_px(1, 3, 7, 1, 1);
    issue(0, 0, 1, 3, 7);
    wait_idle();

    // Zero-length line: one pixel, cmd_ready already up in the line_done cycle.
    push_px(7, 9, 1, 1, 1);
    issue(7, 9, 7, 9, 1);
    got_done = 0;
    for (int i = 0; i < 20 && !got_done; i++) begin
      @(negedge clk_sys);
      if (line_done) got_done = 1;
    end
    check("zero_len_done_seen", got_done, 1'b1);
    check("zero_len_ready_with_done", cmd_ready, 1'b1);
    @(negedge clk_sys);
    check("zero_len_busy_after", busy, 1'b0);
    wait_idle();

    // Stall for three slots after the second write.
    for (int i = 0; i < 10; i++) push_px(i, 0, 3, 1, i == 9);
    wr0 = n_wr;
    issue(0, 0, 9, 0, 3);
    seen = 0;
    for (int i = 0; i < 20 && seen < 2; i++) begin
      @(negedge clk_sys);
      if (pixel_write) seen++;
    end
    check_int("stall_two_writes", seen, 2);
    pixel_wr_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_sys);
      check("stall_gap_write", pixel_write, 1'b0);
    end
    pixel_wr_full = 1'b0;
    wait_idle();
    check_int("stall_total_writes", n_wr - wr0, 10);

    // Back-to-back: second command held pending while the first draws.
    push_px(0, 0, 6, 1, 0);
    push_px(1, 0, 6, 1, 1);
    push_px(3, 3, 4, 1, 0);
    push_px(3, 4, 4, 1, 1);
    issue(0, 0, 1, 0, 6);
    issue(3, 3, 3, 4, 4);
    wait_idle();

    // Reset during the 4th pixel of a long line.
    for (int i = 0; i < 4; i++) push_px(i, 0, 4, 1, 0);
    issue(0, 0, 9, 0, 4);
    seen = 0;
    for (int i = 0; i < 20 && seen < 4; i++) begin
      @(negedge clk_sys);
      if (pixel_write) seen++;
    end
    check_int("rst_four_writes", seen, 4);
    #2 reset_l = 1'b0;
    #1;
    check("rst_async_write", pixel_write, 1'b0);
    check("rst_async_busy", busy, 1'b0);
    check("rst_async_done", line_done, 1'b0);
    @(posedge clk_sys);
    @(negedge clk_sys);
    reset_l = 1'b1;
    @(negedge clk_sys);
    check("rst_release_ready", cmd_ready, 1'b1);
    check_int("rst_pending_pixels", q.size(), 0);
    push_px(1, 1, 6, 1, 0);
    push_px(2, 1, 6, 1, 1);
    issue(1, 1, 2, 1, 6);
    wait_idle();

`ifdef AVG_RAST_CLIP_EN
    // Clip window X_MAX=2: x=3 silent, x=4 only signals line_done.
    for (int i = 0; i < 3; i++) push_px(i, 0, 5, 1, 0);
    push_px(4, 0, 5, 0, 1);
    issue(0, 0, 4, 0, 5);
    wait_idle();
`endif

    check_int("final_queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
